seven_segment_reader: RTL and testbench
=======================================

# seven_segment_reader

Receive-side counterpart to the multiplexed 4-digit 7-segment driver. It samples the anode-select and segment lines, which are either looped back from the driver pins or taken from an external display bus. It accumulates the segments lit during each anode window and decodes each window back to a hex nibble per digit. It is used for self-test of the display path and for reading displays driven by other boards. It tolerates the driver's one-segment-at-a-time scanning within a digit window.

## Interface
- `NUM_DIGITS`, default 4: number of anode lines and digits.
- `SYNC_STAGES`, default 2: synchronizer depth on all inputs, minimum 2.
- `MIN_ON_CYCLES`, default 64: minimum anode-high width in CLK cycles for a window to be committed.
- `CNT_W`, default 16: width of the on-cycle counter, which saturates.

Ports:
- `CLK`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `anode`  in  NUM_DIGITS  active-high digit selects; bit 0 is the least significant digit.
- `segment_n`  in  7  active-low segments; bit 6 = a … bit 0 = g.
- `digits`  out  4*NUM_DIGITS  decoded nibbles; digit i is at [4i+3:4i].
- `digit_valid`  out  NUM_DIGITS  set when digit i's last committed window was a legal glyph.
- `update`  out  1  single-cycle pulse when any `digits`/`digit_valid` bit changes.
- `glyph_error`  out  1  single-cycle pulse when a committed window holds a non-blank, non-table pattern.
- `overlap_error`  out  1  single-cycle pulse when more than one anode is high.

## Operation
- All of `anode` and `segment_n` pass through SYNC_STAGES flops before any use.
- State machine:
  - **IDLE**: no anode is high.
  - **ACCUM**: exactly one anode is high. Latch its index, OR `~segment_n` into a 7-bit `lit` register every cycle, and increment the on-counter, saturating at 2^CNT_W−1.
  - **Commit** is an action, not a state. It fires on exit from ACCUM when the anode falls or switches index.
- Commit rules:
  - If the on-count is below MIN_ON_CYCLES, discard the window: no output change, no pulse.
  - Decode `lit` using this active-low table (a..g):
    - 0=0000001, 1=1001111, 2=0010010, 3=0000110
    - 4=1001100, 5=0100100, 6=0100000, 7=0001111
    - 8=0000000, 9=0000100, A=0001000, b=1100000
    - c=1110010, d=1000010, E=0110000, F=0111000
  - Match: write the nibble and set `digit_valid[i]`.
  - Blank window (nothing lit): clear `digit_valid[i]` and leave the nibble unchanged. No error.
  - Other pattern: clear `digit_valid[i]` and pulse `glyph_error`.
  - `update` pulses only if the stored nibble or valid bit actually changed.
- Direct switch from anode i to anode j in one cycle, which is normal driver behaviour:
  - Commit window i.
  - Start window j in the same cycle. `lit` and the counter load the current sample rather than OR-ing into the old value.
  - No cycle is lost.
- Two or more anodes high:
  - Abort the current window with no commit.
  - Pulse `overlap_error` once on entry.
  - Stay in IDLE until zero or exactly one anode is high. Exactly one high starts a fresh ACCUM.
- Only `lit` and the counter reset per window. Other digits' outputs are held indefinitely.

## Timing
- Reset values: `digits`=0, `digit_valid`=0, `update`=0, `glyph_error`=0, `overlap_error`=0, state IDLE, `lit`=0, counter 0.
- Asserting `reset` mid-window discards the window with no commit. Outputs return to reset values asynchronously.
- Latency: an anode edge at the pin produces the `digits`/`digit_valid` change and the pulses SYNC_STAGES+1 CLK cycles later. All outputs are registered.
- The pulses are exactly one cycle wide. `update` and `glyph_error` may coincide only if the valid bit fell.
- The counter saturates and never wraps. Arbitrarily long windows still commit.

## Configuration
- `SEVEN_SEGMENT_READER_CONFIRM_EN` defined:
  - A digit's outputs change only after two consecutive committed windows for that digit decode to the same result (nibble plus valid/blank/error class).
  - A per-digit pending register holds the first result.
  - `glyph_error` still pulses on every bad window.
- Not defined: every committed window updates immediately, and there is no pending storage.

## Structure
- Package `seven_segment_pkg`:
  - Glyph table constants, shared with the driver.
  - Segment bit-index constants a..g.
  - Reader state enum.
- Sub-module `seven_segment_glyph_decoder`: combinational; 7-bit `lit` in; {match, blank, nibble} out.
- Synchronizer flops stay inline.

## Test plan
- Drive anode=0001 for 100 cycles with segments scanned one at a time showing "7" (a,b,c lit), then 0000 → after SYNC_STAGES+1 cycles `digits[3:0]`=7, `digit_valid[0]`=1, one `update` pulse.
- Drive anodes 0001→0010→0100→1000 back-to-back (direct switches), 80 cycles each, showing 1,2,3,4 → `digits`=16'h4321, `digit_valid`=4'hF, four `update` pulses. Repeating the same frame gives no further `update`.
- Drive anode=0010 for 40 cycles showing "8" (below MIN_ON_CYCLES=64) → no change, no pulses.
- Drive anode=0100 for 100 cycles with only segment a lit → `glyph_error` pulses once, `digit_valid[2]`=0. Then a blank window clears valid with no error.
- Drive anode=0011 in the middle of a window → one `overlap_error` pulse and the window is aborted. Then anode=0001 showing "F" commits F normally.
- Assert `reset` mid-window after prior digits are loaded → all outputs 0 immediately; no commit after release. With CONFIRM_EN, a single "5" window gives no update and a second gives an update.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_pkg                                               |
// | Brief    : Shared glyph table, segment bit indices and reader state enum.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package seven_segment_pkg;

   localparam int c_seg_a = 6;
   localparam int c_seg_b = 5;
   localparam int c_seg_c = 4;
   localparam int c_seg_d = 3;
   localparam int c_seg_e = 2;
   localparam int c_seg_f = 1;
   localparam int c_seg_g = 0;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } reader_state_t;

   // Active-low segment pattern (bit 6 = a .. bit 0 = g) for each hex nibble.
   function automatic logic [6:0] glyph_n(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = 7'b0000001;
         4'h1:    code = 7'b1001111;
         4'h2:    code = 7'b0010010;
         4'h3:    code = 7'b0000110;
         4'h4:    code = 7'b1001100;
         4'h5:    code = 7'b0100100;
         4'h6:    code = 7'b0100000;
         4'h7:    code = 7'b0001111;
         4'h8:    code = 7'b0000000;
         4'h9:    code = 7'b0000100;
         4'hA:    code = 7'b0001000;
         4'hB:    code = 7'b1100000;
         4'hC:    code = 7'b1110010;
         4'hD:    code = 7'b1000010;
         4'hE:    code = 7'b0110000;
         default: code = 7'b0111000;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_glyph_decoder.sv
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_glyph_decoder                                     |
// | Brief    : Maps an accumulated active-high segment set back to a nibble.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module seven_segment_glyph_decoder
   import seven_segment_pkg::*;
(
   input  logic [6:0] i_lit,
   output logic       o_match,
   output logic       o_blank,
   output logic [3:0] o_nibble
);

   always_comb begin
      o_match  = 1'b0;
      o_nibble = 4'h0;
      for (int k = 0; k < 16; k++) begin
         if (i_lit == ~glyph_n(4'(k))) begin
            o_match  = 1'b1;
            o_nibble = 4'(k);
         end
      end
   end

   assign o_blank = (i_lit == 7'h00);

endmodule

`default_nettype wire

// File: rtl/seven_segment_reader.sv
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_reader                                            |
// | Brief    : Samples a multiplexed 7-segment bus and decodes each digit.     |
// |            SEVEN_SEGMENT_READER_CONFIRM_EN: require two matching windows.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module seven_segment_reader
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_ON_CYCLES = 64,
   parameter int CNT_W         = 16
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic [NUM_DIGITS-1:0]   anode,
   input  logic [6:0]              segment_n,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic                    glyph_error,
   output logic                    overlap_error
);

   localparam int               c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] c_min_on = CNT_W'(MIN_ON_CYCLES);

   logic [NUM_DIGITS-1:0] r_anode_sync [SYNC_STAGES];
   logic [6:0]            r_seg_sync   [SYNC_STAGES];

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_anode_sync[s] <= '0;
            r_seg_sync[s]   <= '1;
         end
      end else begin
         r_anode_sync[0] <= anode;
         r_seg_sync[0]   <= segment_n;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_anode_sync[s] <= r_anode_sync[s-1];
            r_seg_sync[s]   <= r_seg_sync[s-1];
         end
      end
   end

   logic [NUM_DIGITS-1:0] w_anode;
   logic [6:0]            w_lit_now;
   logic [1:0]            w_hot_cnt;
   logic [c_idx_w-1:0]    w_idx;
   logic                  w_one;
   logic                  w_none;
   logic                  w_multi;

   assign w_anode   = r_anode_sync[SYNC_STAGES-1];
   assign w_lit_now = ~r_seg_sync[SYNC_STAGES-1];

   // Hot count saturates at 2; only "none / one / several" matters.
   always_comb begin
      w_hot_cnt = 2'd0;
      w_idx     = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (w_anode[d]) begin
            w_idx = c_idx_w'(d);
            if (w_hot_cnt != 2'd2) w_hot_cnt = w_hot_cnt + 2'd1;
         end
      end
   end

   assign w_none  = (w_hot_cnt == 2'd0);
   assign w_one   = (w_hot_cnt == 2'd1);
   assign w_multi = (w_hot_cnt == 2'd2);

   reader_state_t      r_state, w_state_nxt;
   logic [c_idx_w-1:0] r_idx, w_idx_nxt;
   logic [6:0]         r_lit, w_lit_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_commit;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_lit_nxt   = r_lit;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_one) begin
               w_state_nxt = ST_ACCUM;
               w_idx_nxt   = w_idx;
               w_lit_nxt   = w_lit_now;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         ST_ACCUM: begin
            if (w_one && (w_idx == r_idx)) begin
               w_lit_nxt = r_lit | w_lit_now;
               w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            end else if (w_one) begin
               // Direct switch: close the old window and open the new one this cycle.
               w_commit  = 1'b1;
               w_idx_nxt = w_idx;
               w_lit_nxt = w_lit_now;
               w_cnt_nxt = CNT_W'(1);
            end else begin
               w_commit    = w_none;
               w_state_nxt = ST_IDLE;
               w_lit_nxt   = 7'h00;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_lit   <= 7'h00;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_lit   <= w_lit_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   logic       w_dec_match;
   logic       w_dec_blank;
   logic [3:0] w_dec_nibble;

   seven_segment_glyph_decoder u_decoder (
      .i_lit    (r_lit),
      .o_match  (w_dec_match),
      .o_blank  (w_dec_blank),
      .o_nibble (w_dec_nibble)
   );

   logic [4*NUM_DIGITS-1:0] r_digits, w_digits_nxt;
   logic [NUM_DIGITS-1:0]   r_valid, w_valid_nxt;
   logic                    r_update, r_glyph_err, r_overlap, r_multi_prev;
   logic                    w_commit_ok;
   logic                    w_apply;

`ifdef SEVEN_SEGMENT_READER_CONFIRM_EN
   logic [NUM_DIGITS-1:0]      r_pend_vld;
   logic [NUM_DIGITS-1:0][5:0] r_pend_res;
   logic [5:0]                 w_res;

   // Result class: 0 = glyph, 1 = blank, 2 = illegal pattern.
   assign w_res = {(w_dec_match ? 2'd0 : (w_dec_blank ? 2'd1 : 2'd2)), w_dec_nibble};

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_pend_vld <= '0;
         r_pend_res <= '0;
      end else if (w_commit_ok) begin
         r_pend_vld[r_idx] <= 1'b1;
         r_pend_res[r_idx] <= w_res;
      end
   end
`endif

   always_comb begin
      w_digits_nxt = r_digits;
      w_valid_nxt  = r_valid;
      w_commit_ok  = w_commit && (r_cnt >= c_min_on);
`ifdef SEVEN_SEGMENT_READER_CONFIRM_EN
      w_apply      = w_commit_ok && r_pend_vld[r_idx] && (r_pend_res[r_idx] == w_res);
`else
      w_apply      = w_commit_ok;
`endif
      if (w_apply) begin
         if (w_dec_match) w_digits_nxt[{r_idx, 2'b00} +: 4] = w_dec_nibble;
         w_valid_nxt[r_idx] = w_dec_match;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_digits     <= '0;
         r_valid      <= '0;
         r_update     <= 1'b0;
         r_glyph_err  <= 1'b0;
         r_overlap    <= 1'b0;
         r_multi_prev <= 1'b0;
      end else begin
         r_digits     <= w_digits_nxt;
         r_valid      <= w_valid_nxt;
         r_update     <= (w_digits_nxt != r_digits) || (w_valid_nxt != r_valid);
         r_glyph_err  <= w_commit_ok && !w_dec_match && !w_dec_blank;
         r_overlap    <= w_multi && !r_multi_prev;
         r_multi_prev <= w_multi;
      end
   end

   assign digits        = r_digits;
   assign digit_valid   = r_valid;
   assign update        = r_update;
   assign glyph_error   = r_glyph_err;
   assign overlap_error = r_overlap;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_seven_segment_reader                                         |
// | Brief    : Directed bench with a window-level reference model.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seven_segment_reader;

   localparam int SYNC   = 2;
   localparam int MIN_ON = 64;
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  anode = 4'h0;
   logic [6:0]  segment_n = 7'h7F;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        update, glyph_error, overlap_error;

   int checks = 0;
   int errors = 0;
   int upd_cnt = 0, gerr_cnt = 0, ovl_cnt = 0;

   always #5 CLK = ~CLK;

   seven_segment_reader #(
      .NUM_DIGITS(4), .SYNC_STAGES(SYNC), .MIN_ON_CYCLES(MIN_ON), .CNT_W(16)
   ) dut (
      .CLK(CLK), .reset(reset), .anode(anode), .segment_n(segment_n),
      .digits(digits), .digit_valid(digit_valid), .update(update),
      .glyph_error(glyph_error), .overlap_error(overlap_error)
   );

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  v;
      logic        u;
      logic        g;
      logic        o;
   } obs_t;

   // Model: a window is a maximal run of pin samples with the same single anode.
   obs_t        hist[$];
   logic [15:0] m_d = '0;
   logic [3:0]  m_v = '0;
   bit          run_on = 0;
   logic [3:0]  run_an = '0;
   int          run_len = 0;
   logic [6:0]  run_or = '0;
   bit          m_prev_multi = 0;
   bit          pend_on [4];
   logic [5:0]  pend    [4];

   task automatic model_commit(output logic upd, output logic gerr);
      int          dig, code;
      logic [6:0]  pat;
      logic [15:0] od;
      logic [3:0]  ov;
      logic [5:0]  res;
      bit          apply;
      upd = 1'b0;
      gerr = 1'b0;
      if (run_len < MIN_ON) return;
      dig = 0;
      for (int b = 0; b < 4; b++) if (run_an[b]) dig = b;
      code = -1;
      for (int k = 0; k < 16; k++) begin
         pat = GLYPH[k];
         if (~pat == run_or) code = k;
      end
      gerr = (code < 0) && (run_or != 7'h00);
      res = (code >= 0) ? {2'd0, 4'(code)} : ((run_or == 7'h00) ? 6'h10 : 6'h20);
`ifdef SEVEN_SEGMENT_READER_CONFIRM_EN
      apply = pend_on[dig] && (pend[dig] == res);
      pend_on[dig] = 1;
      pend[dig] = res;
`else
      apply = 1;
`endif
      od = m_d;
      ov = m_v;
      if (apply) begin
         if (code >= 0) m_d[dig*4 +: 4] = 4'(code);
         m_v[dig] = (code >= 0);
      end
      upd = (od != m_d) || (ov != m_v);
   endtask

   always @(posedge CLK) begin : model
      obs_t o;
      int   ones;
      o = '0;
      if (reset) begin
         m_d = '0;
         m_v = '0;
         run_on = 0;
         m_prev_multi = 0;
         for (int i = 0; i < 4; i++) begin pend_on[i] = 0; pend[i] = '0; end
         for (int i = hist.size() - SYNC; i < hist.size(); i++) if (i >= 0) hist[i] = '0;
         hist.push_back('0);
      end else begin
         ones = $countones(anode);
         if (run_on && !(ones == 1 && anode == run_an)) begin
            if (ones < 2) model_commit(o.u, o.g);
            run_on = 0;
         end
         if (ones == 1 && !run_on) begin
            run_on = 1; run_an = anode; run_len = 0; run_or = '0;
         end
         if (run_on) begin
            run_len++;
            run_or = run_or | ~segment_n;
         end
         o.o = (ones >= 2) && !m_prev_multi;
         m_prev_multi = (ones >= 2);
         o.d = m_d;
         o.v = m_v;
         hist.push_back(o);
      end
   end

   always @(posedge CLK) begin : compare
      obs_t exp_o, act_o;
      #1;
      exp_o = (hist.size() > SYNC) ? hist[hist.size()-1-SYNC] : '0;
      act_o = {digits, digit_valid, update, glyph_error, overlap_error};
      checks++;
      if (act_o !== exp_o) begin
         errors++;
         $display("FAIL model_cmp t=%0t got d=%h v=%h u=%b g=%b o=%b, expected d=%h v=%h u=%b g=%b o=%b",
                  $time, act_o.d, act_o.v, act_o.u, act_o.g, act_o.o,
                  exp_o.d, exp_o.v, exp_o.u, exp_o.g, exp_o.o);
      end
      if (update) upd_cnt++;
      if (glyph_error) gerr_cnt++;
      if (overlap_error) ovl_cnt++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp_v);
      end
   endtask

   // Shows one glyph on one anode, lighting a single segment per cycle.
   task automatic drive_window(input logic [3:0] an, input logic [6:0] gn, input int cycles);
      logic [6:0] lit;
      int         bits[$];
      lit = ~gn;
      for (int b = 0; b < 7; b++) if (lit[b]) bits.push_back(b);
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         anode = an;
         segment_n = 7'h7F;
         if (bits.size() > 0) segment_n[bits[c % bits.size()]] = 1'b0;
      end
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         anode = 4'h0;
         segment_n = 7'h7F;
      end
   endtask

   int u0, g0, o0;

   initial begin
      repeat (3) @(negedge CLK);
      check("reset_digits", 32'(digits), 32'h0);
      check("reset_valid", 32'(digit_valid), 32'h0);
      check("reset_pulses", {29'd0, update, glyph_error, overlap_error}, 32'h0);
      reset = 1'b0;
      idle(4);

      u0 = upd_cnt;
      drive_window(4'b0001, GLYPH[7], 100);
      idle(6);
`ifndef SEVEN_SEGMENT_READER_CONFIRM_EN
      check("seven_digit", 32'(digits[3:0]), 32'h7);
      check("seven_valid", 32'(digit_valid[0]), 32'h1);
      check("seven_update", upd_cnt - u0, 1);
`endif

      u0 = upd_cnt;
      for (int r = 0; r < 2; r++) begin
         drive_window(4'b0001, GLYPH[1], 80);
         drive_window(4'b0010, GLYPH[2], 80);
         drive_window(4'b0100, GLYPH[3], 80);
         drive_window(4'b1000, GLYPH[4], 80);
         idle(6);
`ifndef SEVEN_SEGMENT_READER_CONFIRM_EN
         check("frame_digits", 32'(digits), 32'h4321);
         check("frame_valid", 32'(digit_valid), 32'hF);
         check("frame_updates", upd_cnt - u0, (r == 0) ? 4 : 0);
`endif
         u0 = upd_cnt;
      end

      u0 = upd_cnt; g0 = gerr_cnt;
      drive_window(4'b0010, GLYPH[8], 40);
      idle(6);
      check("short_updates", upd_cnt - u0, 0);
      check("short_gerr", gerr_cnt - g0, 0);

      u0 = upd_cnt; g0 = gerr_cnt;
      drive_window(4'b0100, 7'b0111111, 100);
      idle(6);
      check("bad_gerr", gerr_cnt - g0, 1);
      check("bad_valid2", 32'(digit_valid[2]), 32'h0);
`ifndef SEVEN_SEGMENT_READER_CONFIRM_EN
      check("bad_update", upd_cnt - u0, 1);
      u0 = upd_cnt; g0 = gerr_cnt;
      drive_window(4'b1000, 7'h7F, 100);
      idle(6);
      check("blank_gerr", gerr_cnt - g0, 0);
      check("blank_valid", 32'(digit_valid), 32'h3);
      check("blank_digits", 32'(digits), 32'h4321);
`endif

      u0 = upd_cnt; o0 = ovl_cnt;
      drive_window(4'b0001, GLYPH[0], 70);
      drive_window(4'b0011, 7'h7F, 10);
      drive_window(4'b0001, GLYPH[15], 100);
      idle(6);
      check("ovl_pulses", ovl_cnt - o0, 1);
`ifndef SEVEN_SEGMENT_READER_CONFIRM_EN
      check("ovl_digits", 32'(digits), 32'h432F);
      check("ovl_update", upd_cnt - u0, 1);
`endif

      u0 = upd_cnt;
      drive_window(4'b0010, GLYPH[9], 50);
      reset = 1'b1;
      #1;
      check("async_rst_digits", 32'(digits), 32'h0);
      check("async_rst_valid", 32'(digit_valid), 32'h0);
      drive_window(4'b0010, GLYPH[9], 3);
      idle(1);
      reset = 1'b0;
      idle(8);
      check("post_rst_digits", 32'(digits), 32'h0);

      u0 = upd_cnt;
      drive_window(4'b0001, GLYPH[5], 100);
      idle(6);
`ifdef SEVEN_SEGMENT_READER_CONFIRM_EN
      check("five_first_update", upd_cnt - u0, 0);
      check("five_first_digits", 32'(digits), 32'h0);
`else
      check("five_first_update", upd_cnt - u0, 1);
      check("five_first_digits", 32'(digits), 32'h5);
`endif
      u0 = upd_cnt;
      drive_window(4'b0001, GLYPH[5], 100);
      idle(6);
`ifdef SEVEN_SEGMENT_READER_CONFIRM_EN
      check("five_second_update", upd_cnt - u0, 1);
`else
      check("five_second_update", upd_cnt - u0, 0);
`endif
      check("five_digits", 32'(digits), 32'h5);
      check("five_valid", 32'(digit_valid), 32'h1);

      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
